mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS memory-access stage, directly downstream of EX.
- Consumes EX's Result (effective address or ALU value), the forwarded Rdata2 (store data) and Ins.
- Performs loads and stores over a req/ack data-memory bus, stalling upstream until the access completes.
- Hands a registered result to write-back.

Parameters:
- TIMEOUT, 255: max cycles to wait for MemAck; used only with the optional feature.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- InValid  in  1  Ins/Result/Rdata2 carry a valid instruction this cycle
- Ins  in  32  instruction from EX
- Result  in  32  EX result: effective address for load/store, else value to pass
- Rdata2  in  32  store data
- Stall  out  1  upstream must hold its outputs and not advance
- MemReq  out  1  bus request, held until MemAck
- MemWe  out  1  1 = write
- MemAddr  out  32  word-aligned address, {Result[31:2],2'b00}
- MemBe  out  4  byte enables, little-endian (lane0 = bits 7:0)
- MemWdata  out  32  write data
- MemRdata  in  32  read data, valid with MemAck
- MemAck  in  1  one-cycle completion strobe
- WBvalid  out  1  WBdata/WBins valid for write-back
- WBdata  out  32  load result or passed-through Result
- WBins  out  32  instruction forwarded to write-back
- AddrErr  out  1  one-cycle pulse: misaligned access, no bus cycle
- BusErr  out  1  one-cycle pulse: bus timeout (optional feature only)

Behaviour:
- Reset (RST=0, async): state IDLE. MemReq, MemWe, MemAddr, MemBe, MemWdata, WBvalid, WBdata, WBins, AddrErr, BusErr all 0. Timeout counter 0.
- Memory opcodes (Ins[31:26]):
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - All other opcodes are non-memory.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, InValid=1, non-memory op: next edge WBvalid=1, WBdata=Result, WBins=Ins. Stall=0. Latency 1 cycle.
- IDLE, InValid=1, misaligned memory op (LH/LHU/SH with Result[0]=1; LW/SW with Result[1:0]!=0): next edge AddrErr=1, WBvalid=0, no bus request. Stall=0.
- IDLE, InValid=1, aligned memory op:
  - Latch Ins, Result and Rdata2. Drive MemReq=1 and MemAddr/MemBe/MemWe/MemWdata registered at the next edge. Go to ACCESS.
  - Stall=1 combinationally in this cycle.
- ACCESS: Stall=1. MemReq and all bus outputs held stable. On MemAck=1: MemReq=0 at the next edge, capture and format read data, go to RESP.
- RESP: Stall=0. WBvalid=1 for exactly one cycle. Next state is IDLE. A new InValid in RESP is not accepted; upstream is still stalled on the prior cycle boundary, so it cannot issue one.
- Stall in IDLE = InValid & aligned memory op. Stall in ACCESS = 1. Stall in RESP = 0.
- Store formatting:
  - SB: MemWdata = {4{Rdata2[7:0]}}, MemBe = 4'b0001 << Result[1:0].
  - SH: MemWdata = {2{Rdata2[15:0]}}, MemBe = Result[1] ? 4'b1100 : 4'b0011.
  - SW: MemWdata = Rdata2, MemBe = 4'b1111.
  - Store WBdata = 0; WBvalid still pulses so write-back retires it.
- Load formatting:
  - Loads drive MemBe = 4'b1111 and MemWe = 0.
  - Select the byte or half by Result[1:0]/Result[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- WBvalid, AddrErr and BusErr are single-cycle pulses; all other WB outputs hold until the next update.
- MemAck outside ACCESS is ignored.
- Reset mid-ACCESS: MemReq drops immediately (async); the transaction is abandoned and the memory model must tolerate this.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle without MemAck.
  - When the count reaches TIMEOUT: MemReq=0, BusErr pulses 1 cycle, WBvalid=0, state returns to IDLE.
  - A MemAck in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely. BusErr is tied to 0.

Decomposition:
- Shared package mips_pkg: opcode localparams (OP_LB..OP_SW), the state enum {IDLE, ACCESS, RESP}, and a byte-lane/extension-kind typedef.
- One natural sub-module, mem_align: a combinational store-lane generator and load extractor/extender (size, signedness, Result[1:0]). The FSM stays in mem_stage.

Test Plan:
- ADD passthrough: Ins opcode 0x00, Result=32'h0000_0005, InValid=1 -> next cycle WBvalid=1, WBdata=5, Stall never high, MemReq never high.
- LB sign-extend: Result=32'h0000_0102, MemRdata=32'h11_80_22_33, MemAck 3 cycles after MemReq -> MemAddr=32'h100, MemBe=4'hF, Stall high throughout ACCESS, WBdata=32'hFFFF_FF80, one WBvalid pulse; LBU at the same address gives 32'h80.
- SH upper half: Result=32'h0000_0042, Rdata2=32'hDEAD_BEEF -> MemWe=1, MemBe=4'b1100, MemWdata=32'hBEEF_BEEF, WBvalid pulse with WBdata=0.
- Misaligned LW: Result=32'h0000_0006 -> AddrErr pulse next cycle, MemReq stays 0, WBvalid stays 0.
- Reset mid-access: assert RST=0 while in ACCESS -> MemReq=0 immediately without a clock edge, all outputs 0; after release, an ADD completes normally.
- MEM_TIMEOUT_EN with TIMEOUT=4, MemAck never asserted -> MemReq drops after 4 ACCESS cycles, BusErr pulses once, Stall falls, FSM in IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode constants, FSM state and access-kind types for the MIPS memory stage.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Access width plus load extension; stores reuse the unsigned byte/half kinds.
    typedef enum logic [2:0] {EXT_BS, EXT_BU, EXT_HS, EXT_HU, EXT_W} ext_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic ext_t op_ext(input logic [5:0] op);
        case (op)
            OP_LB:          return EXT_BS;
            OP_LBU, OP_SB:  return EXT_BU;
            OP_LH:          return EXT_HS;
            OP_LHU, OP_SH:  return EXT_HU;
            default:        return EXT_W;
        endcase
    endfunction

    function automatic logic misaligned(input ext_t ext, input logic [1:0] offs);
        case (ext)
            EXT_HS, EXT_HU: return offs[0];
            EXT_W:          return offs != 2'b00;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational store lane replication / byte enables and load byte-half extraction with extension.
module mem_align
    import mips_pkg::*;
(
    input  ext_t        ext,
    input  logic [1:0]  offs,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        case (ext)
            EXT_BS, EXT_BU: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << offs;
            end
            EXT_HS, EXT_HU: begin
                wdata = {2{store_data[15:0]}};
                be    = offs[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        sel_byte = rdata[7:0];
        case (offs)
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            2'd3:    sel_byte = rdata[31:24];
            default: ;
        endcase
        sel_half = offs[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (ext)
            EXT_BS:  load_data = {{24{sel_byte[7]}}, sel_byte};
            EXT_BU:  load_data = {24'h0, sel_byte};
            EXT_HS:  load_data = {{16{sel_half[15]}}, sel_half};
            EXT_HU:  load_data = {16'h0, sel_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: req/ack data bus, upstream stall, registered write-back result.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        InValid,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    input  logic        MemAck,
    output logic        WBvalid,
    output logic [31:0] WBdata,
    output logic [31:0] WBins,
    output logic        AddrErr,
    output logic        BusErr
);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("mem_stage: TIMEOUT must be at least 1");
    end

    state_t      state, state_nxt;
    logic [5:0]  op;
    logic        op_load, op_store, op_mem, op_bad;
    ext_t        ext_live, ext_q, ext_sel;
    logic [1:0]  offs_q, offs_sel;
    logic [31:0] ins_q;
    logic [31:0] gen_wdata, load_data;
    logic [3:0]  gen_be;
    logic        accept_mem;
    logic        time_out;

    assign op         = Ins[31:26];
    assign op_load    = is_load(op);
    assign op_store   = is_store(op);
    assign op_mem     = op_load | op_store;
    assign ext_live   = op_ext(op);
    assign op_bad     = misaligned(ext_live, Result[1:0]);
    assign accept_mem = (state == IDLE) & InValid & op_mem & ~op_bad;

    // Live operands format the store on entry; latched ones format the load on ack.
    assign ext_sel  = (state == IDLE) ? ext_live : ext_q;
    assign offs_sel = (state == IDLE) ? Result[1:0] : offs_q;

    mem_align u_align (
        .ext        (ext_sel),
        .offs       (offs_sel),
        .store_data (Rdata2),
        .rdata      (MemRdata),
        .wdata      (gen_wdata),
        .be         (gen_be),
        .load_data  (load_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] to_cnt;

    // Fires on the last permitted ACCESS cycle; a simultaneous MemAck takes priority.
    assign time_out = (state == ACCESS) & ~MemAck & (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt <= '0;
            BusErr <= 1'b0;
        end else begin
            BusErr <= time_out;
            if (state != ACCESS)
                to_cnt <= '0;
            else if (!MemAck)
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign time_out = 1'b0;
    assign BusErr   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        case (state)
            IDLE: begin
                Stall = accept_mem;
                if (accept_mem)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                Stall = 1'b1;
                if (MemAck)
                    state_nxt = RESP;
                else if (time_out)
                    state_nxt = IDLE;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemBe    <= '0;
            MemWdata <= '0;
            WBvalid  <= 1'b0;
            WBdata   <= '0;
            WBins    <= '0;
            AddrErr  <= 1'b0;
            ins_q    <= '0;
            ext_q    <= EXT_BS;
            offs_q   <= '0;
        end else begin
            WBvalid <= 1'b0;
            AddrErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (InValid && !op_mem) begin
                        WBvalid <= 1'b1;
                        WBdata  <= Result;
                        WBins   <= Ins;
                    end else if (InValid && op_bad) begin
                        AddrErr <= 1'b1;
                    end else if (accept_mem) begin
                        MemReq   <= 1'b1;
                        MemWe    <= op_store;
                        MemAddr  <= {Result[31:2], 2'b00};
                        MemBe    <= op_store ? gen_be : 4'b1111;
                        MemWdata <= op_store ? gen_wdata : 32'h0;
                        ins_q    <= Ins;
                        ext_q    <= ext_live;
                        offs_q   <= Result[1:0];
                    end
                end
                ACCESS: begin
                    if (MemAck) begin
                        MemReq  <= 1'b0;
                        WBvalid <= 1'b1;
                        WBdata  <= MemWe ? 32'h0 : load_data;
                        WBins   <= ins_q;
                    end else if (time_out) begin
                        MemReq <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: write-back results checked through a scoreboard queue.
module tb_mem_stage;
    import mips_pkg::*;

    logic        CLK, RST, InValid, MemAck;
    logic [31:0] Ins, Result, Rdata2, MemRdata;
    logic        Stall, MemReq, MemWe, WBvalid, AddrErr, BusErr;
    logic [31:0] MemAddr, MemWdata, WBdata, WBins;
    logic [3:0]  MemBe;

    typedef struct {
        logic [31:0] data;
        logic [31:0] ins;
    } wb_t;

    wb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wb_seen = 0;
    int  n_push = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .InValid(InValid), .Ins(Ins), .Result(Result),
        .Rdata2(Rdata2), .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemBe(MemBe), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemAck(MemAck), .WBvalid(WBvalid),
        .WBdata(WBdata), .WBins(WBins), .AddrErr(AddrErr), .BusErr(BusErr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin : wb_monitor
        wb_t e;
        if (RST === 1'b1 && WBvalid === 1'b1) begin
            wb_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL wb_unexpected: observed WBvalid=1 expected no write-back");
            end else begin
                e = sb_q.pop_front();
                chk("wb_data", WBdata, e.data);
                chk("wb_ins", WBins, e.ins);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        InValid = 1'b0;
        Ins     = '0;
        Result  = '0;
        Rdata2  = '0;
    endtask

    task automatic pass_op(input string tag, input logic [31:0] ins, input logic [31:0] res);
        Ins = ins; Result = res; InValid = 1'b1;
        sb_q.push_back('{data: res, ins: ins});
        n_push++;
        #1 chk({tag, "_stall"}, Stall, 0);
        step();
        clear_in();
        chk({tag, "_memreq"}, MemReq, 0);
        chk({tag, "_wbvalid"}, WBvalid, 1);
        step();
        chk({tag, "_wbvalid_pulse"}, WBvalid, 0);
    endtask

    task automatic mem_op(input string tag, input logic [5:0] op, input logic [31:0] res,
                          input logic [31:0] rd2, input logic [31:0] rdata, input int delay,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic exp_we, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_wb);
        Ins = {op, 26'h0155AA3}; Result = res; Rdata2 = rd2; InValid = 1'b1;
        sb_q.push_back('{data: exp_wb, ins: Ins});
        n_push++;
        #1 chk({tag, "_stall_req"}, Stall, 1);
        step();
        clear_in();
        chk({tag, "_memreq"}, MemReq, 1);
        chk({tag, "_addr"}, MemAddr, exp_addr);
        chk({tag, "_be"}, MemBe, exp_be);
        chk({tag, "_we"}, MemWe, exp_we);
        if (exp_we)
            chk({tag, "_wdata"}, MemWdata, exp_wdata);
        for (int i = 0; i < delay - 1; i++) begin
            chk({tag, "_stall_acc"}, Stall, 1);
            chk({tag, "_req_hold"}, MemReq, 1);
            chk({tag, "_addr_hold"}, MemAddr, exp_addr);
            step();
        end
        MemAck = 1'b1; MemRdata = rdata;
        chk({tag, "_stall_ack"}, Stall, 1);
        step();
        MemAck = 1'b0; MemRdata = '0;
        chk({tag, "_req_drop"}, MemReq, 0);
        chk({tag, "_stall_resp"}, Stall, 0);
        chk({tag, "_wbvalid"}, WBvalid, 1);
        step();
        chk({tag, "_wbvalid_pulse"}, WBvalid, 0);
    endtask

    task automatic bad_op(input string tag, input logic [5:0] op, input logic [31:0] res);
        Ins = {op, 26'h0000777}; Result = res; InValid = 1'b1;
        #1 chk({tag, "_stall"}, Stall, 0);
        step();
        clear_in();
        chk({tag, "_addrerr"}, AddrErr, 1);
        chk({tag, "_memreq"}, MemReq, 0);
        chk({tag, "_wbvalid"}, WBvalid, 0);
        step();
        chk({tag, "_addrerr_pulse"}, AddrErr, 0);
        chk({tag, "_memreq2"}, MemReq, 0);
    endtask

    initial begin
        RST = 1'b1; MemAck = 1'b0; MemRdata = '0;
        clear_in();
        #1 RST = 1'b0;
        #1;
        chk("rst_memreq", MemReq, 0);
        chk("rst_memwe", MemWe, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_be", MemBe, 0);
        chk("rst_wdata", MemWdata, 0);
        chk("rst_wbvalid", WBvalid, 0);
        chk("rst_wbdata", WBdata, 0);
        chk("rst_wbins", WBins, 0);
        chk("rst_addrerr", AddrErr, 0);
        chk("rst_buserr", BusErr, 0);
        chk("rst_stall", Stall, 0);
        step();
        step();
        RST = 1'b1;
        step();

        pass_op("add", 32'h0022_1820, 32'h0000_0005);
        pass_op("or", 32'h0043_2025, 32'hCAFE_F00D);

        mem_op("lb", OP_LB, 32'h0000_0102, 32'h0, 32'h1180_2233, 3,
               32'h0000_0100, 4'hF, 1'b0, 32'h0, 32'hFFFF_FF80);
        mem_op("lbu", OP_LBU, 32'h0000_0102, 32'h0, 32'h1180_2233, 3,
               32'h0000_0100, 4'hF, 1'b0, 32'h0, 32'h0000_0080);
        mem_op("sh_hi", OP_SH, 32'h0000_0042, 32'hDEAD_BEEF, 32'h0, 2,
               32'h0000_0040, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0);
        mem_op("sh_lo", OP_SH, 32'h0000_0040, 32'h1234_A5C3, 32'h0, 1,
               32'h0000_0040, 4'b0011, 1'b1, 32'hA5C3_A5C3, 32'h0);
        mem_op("sb_3", OP_SB, 32'h0000_0207, 32'h0000_00A5, 32'h0, 1,
               32'h0000_0204, 4'b1000, 1'b1, 32'hA5A5_A5A5, 32'h0);
        mem_op("sw", OP_SW, 32'h0000_0200, 32'h1234_5678, 32'h0, 4,
               32'h0000_0200, 4'hF, 1'b1, 32'h1234_5678, 32'h0);
        mem_op("lh_hi", OP_LH, 32'h0000_0302, 32'h0, 32'h9ABC_1234, 2,
               32'h0000_0300, 4'hF, 1'b0, 32'h0, 32'hFFFF_9ABC);
        mem_op("lhu_hi", OP_LHU, 32'h0000_0302, 32'h0, 32'h9ABC_1234, 1,
               32'h0000_0300, 4'hF, 1'b0, 32'h0, 32'h0000_9ABC);
        mem_op("lh_lo", OP_LH, 32'h0000_0300, 32'h0, 32'h9ABC_1234, 1,
               32'h0000_0300, 4'hF, 1'b0, 32'h0, 32'h0000_1234);
        mem_op("lw", OP_LW, 32'h0000_0ABC, 32'h0, 32'h8765_4321, 2,
               32'h0000_0ABC, 4'hF, 1'b0, 32'h0, 32'h8765_4321);

        bad_op("lw_mis", OP_LW, 32'h0000_0006);
        bad_op("sh_mis", OP_SH, 32'h0000_0011);

        // Stray ack while idle must do nothing.
        MemAck = 1'b1; MemRdata = 32'hFFFF_FFFF;
        step();
        MemAck = 1'b0; MemRdata = '0;
        chk("stray_ack_wbvalid", WBvalid, 0);
        chk("stray_ack_memreq", MemReq, 0);

        // Reset while a load waits for its ack.
        Ins = {OP_LW, 26'h0000123}; Result = 32'h0000_0300; InValid = 1'b1;
        step();
        clear_in();
        chk("rma_memreq_before", MemReq, 1);
        step();
        #2 RST = 1'b0;
        #1;
        chk("rma_memreq", MemReq, 0);
        chk("rma_addr", MemAddr, 0);
        chk("rma_be", MemBe, 0);
        chk("rma_wbvalid", WBvalid, 0);
        chk("rma_stall", Stall, 0);
        step();
        RST = 1'b1;
        step();
        pass_op("add_after_rst", 32'h0022_1820, 32'h0000_0009);

`ifdef MEM_TIMEOUT_EN
        Ins = {OP_LW, 26'h0000456}; Result = 32'h0000_0400; InValid = 1'b1;
        step();
        clear_in();
        for (int i = 0; i < 4; i++) begin
            chk("to_memreq_wait", MemReq, 1);
            chk("to_stall_wait", Stall, 1);
            chk("to_buserr_wait", BusErr, 0);
            step();
        end
        chk("to_memreq_drop", MemReq, 0);
        chk("to_buserr", BusErr, 1);
        chk("to_stall", Stall, 0);
        chk("to_wbvalid", WBvalid, 0);
        step();
        chk("to_buserr_pulse", BusErr, 0);
        pass_op("add_after_to", 32'h0022_1820, 32'h0000_0077);
`else
        chk("buserr_tied", BusErr, 0);
`endif

        step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("wb_count", 32'(wb_seen), 32'(n_push));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
